// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : adc_pkg
// Description : Shared types and width helpers for the ADC frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // Sequencer states; the top keeps them as fixed-width constants.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        QUIET = 2'd2
    } adc_state_e;

    localparam int STATE_W = 2;

    // Bits for a counter that runs 0..count-1 (at least one bit).
    function automatic int cnt_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    // Bits for the edge counter, which must be able to hold FRAME_BITS itself.
    function automatic int edge_width(input int frame_bits);
        return $clog2(frame_bits + 1);
    endfunction

    // Lead-in plus payload must fit inside one frame.
    function automatic bit frame_fits(input int lead_zeros, input int data_bits,
                                      input int frame_bits);
        return (lead_zeros + data_bits) <= frame_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sclk_div.sv
`default_nettype none
// ============================================================================
// Module      : adc_sclk_div
// Description : sclk generator. While run is high, a divider toggles sclk
//               every CLK_DIV clk cycles and flags the cycle before each
//               falling / rising toggle. sclk idles high when run is low.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sclk_div
    import adc_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic sclk,
    output logic fall_evt,
    output logic rise_evt
);

    localparam int                 c_div_w    = cnt_width(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    logic [c_div_w-1:0] r_div_cnt;
    logic               r_sclk;
    logic               w_wrap;

    assign w_wrap   = run && (r_div_cnt == c_div_last);
    assign fall_evt = w_wrap && r_sclk;
    assign rise_evt = w_wrap && !r_sclk;
    assign sclk     = r_sclk;

    // Divider and sclk register; restart from a high sclk whenever run drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
        end else if (!run) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b1;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_sclk    <= !r_sclk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : adc_frame_sequencer
// Description : Drives cs_n/sclk for NUM_CH SPI-style ADCs sharing one bus,
//               deserialises each sdata lane MSB-first and emits a parallel
//               sample word with a one-cycle sample_valid strobe.
// Options     : ADC_SEQ_ZERO_CHECK_EN - adds frame_err, flagging any 1 in a
//               lane's leading-zero bits.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_frame_sequencer
    import adc_pkg::*;
#(
    parameter int FRAME_BITS   = 16,
    parameter int LEAD_ZEROS   = 4,
    parameter int DATA_BITS    = 12,
    parameter int CLK_DIV      = 2,
    parameter int QUIET_CYCLES = 2,
    parameter int NUM_CH       = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           sdata,
    output logic                        cs_n,
    output logic                        sclk,
    output logic                        busy,
    output logic                        sample_valid,
    output logic [NUM_CH*DATA_BITS-1:0] sample_data
`ifdef ADC_SEQ_ZERO_CHECK_EN
    ,
    output logic [NUM_CH-1:0]           frame_err
`endif
);

    localparam logic [STATE_W-1:0] c_st_idle  = IDLE;
    localparam logic [STATE_W-1:0] c_st_shift = SHIFT;
    localparam logic [STATE_W-1:0] c_st_quiet = QUIET;

    localparam int c_edge_w  = edge_width(FRAME_BITS);
    localparam int c_quiet_w = cnt_width(QUIET_CYCLES);
    // Only the bits that are ever used are kept per lane; shifting stops once
    // the payload is complete so trailing frame bits never disturb it.
`ifdef ADC_SEQ_ZERO_CHECK_EN
    localparam int c_keep = LEAD_ZEROS + DATA_BITS;
`else
    localparam int c_keep = DATA_BITS;
`endif

    localparam logic [c_edge_w-1:0]  c_edge_last  = c_edge_w'(FRAME_BITS);
    localparam logic [c_edge_w-1:0]  c_edge_used  = c_edge_w'(LEAD_ZEROS + DATA_BITS);
    localparam logic [c_quiet_w-1:0] c_quiet_last = c_quiet_w'(QUIET_CYCLES - 1);

    generate
        if (!frame_fits(LEAD_ZEROS, DATA_BITS, FRAME_BITS) || CLK_DIV < 1 ||
            QUIET_CYCLES < 1 || DATA_BITS < 1 || NUM_CH < 1) begin : g_bad_params
            $error("adc_frame_sequencer: illegal parameter combination");
        end
    endgenerate

    logic [STATE_W-1:0]          r_state;
    logic [c_edge_w-1:0]         r_edge_cnt;
    logic [c_quiet_w-1:0]        r_quiet_cnt;
    logic                        r_cs_n;
    logic                        r_sample_valid;
    logic [NUM_CH*DATA_BITS-1:0] r_sample_data;
    logic [c_keep-1:0]           r_shift [NUM_CH];

    logic                        w_run;
    logic                        w_fall;
    logic                        w_rise;
    logic                        w_frame_done;
    logic                        w_quiet_done;
    logic [NUM_CH*DATA_BITS-1:0] w_payload;

    assign w_run        = (r_state == c_st_shift);
    assign w_frame_done = w_run && w_rise && (r_edge_cnt == c_edge_last);
    assign w_quiet_done = (r_quiet_cnt == c_quiet_last);

    assign cs_n         = r_cs_n;
    assign busy         = (r_state != c_st_idle);
    assign sample_valid = r_sample_valid;
    assign sample_data  = r_sample_data;

    adc_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (w_run),
        .sclk     (sclk),
        .fall_evt (w_fall),
        .rise_evt (w_rise)
    );

    // Frame sequencer: IDLE -> SHIFT (cs_n low) -> QUIET (cs_n high) -> ...
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_st_idle;
            r_cs_n      <= 1'b1;
            r_edge_cnt  <= '0;
            r_quiet_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (enable) begin
                        r_state    <= c_st_shift;
                        r_cs_n     <= 1'b0;
                        r_edge_cnt <= '0;
                    end
                end
                c_st_shift: begin
                    if (w_fall) begin
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                    end
                    if (w_frame_done) begin
                        r_state     <= c_st_quiet;
                        r_cs_n      <= 1'b1;
                        r_quiet_cnt <= '0;
                    end
                end
                c_st_quiet: begin
                    if (w_quiet_done) begin
                        if (enable) begin
                            r_state    <= c_st_shift;
                            r_cs_n     <= 1'b0;
                            r_edge_cnt <= '0;
                        end else begin
                            r_state <= c_st_idle;
                        end
                    end else begin
                        r_quiet_cnt <= r_quiet_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_cs_n  <= 1'b1;
                end
            endcase
        end
    end

    // Per-lane deserialiser: capture on each sclk fall until the payload is in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_shift[c] <= '0;
            end
        end else if (w_run && w_fall && (r_edge_cnt < c_edge_used)) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_shift[c] <= (r_shift[c] << 1) | c_keep'(sdata[c]);
            end
        end
    end

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
            assign w_payload[c*DATA_BITS +: DATA_BITS] = r_shift[c][DATA_BITS-1:0];
        end
    endgenerate

    // Output word and strobe, loaded as the frame closes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
        end else begin
            r_sample_valid <= w_frame_done;
            if (w_frame_done) begin
                r_sample_data <= w_payload;
            end
        end
    end

`ifdef ADC_SEQ_ZERO_CHECK_EN
    logic [NUM_CH-1:0] w_lead_err;
    logic [NUM_CH-1:0] r_frame_err;

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_zero_chk
            if (LEAD_ZEROS > 0) begin : g_has_lead
                assign w_lead_err[c] = |r_shift[c][c_keep-1 -: LEAD_ZEROS];
            end else begin : g_no_lead
                assign w_lead_err[c] = 1'b0;
            end
        end
    endgenerate

    // Leading-zero violation flags, refreshed together with the sample word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_err <= '0;
        end else if (w_frame_done) begin
            r_frame_err <= w_lead_err;
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_frame_sequencer
// Description : Self-checking bench for adc_frame_sequencer. Behavioural ADCs
//               stream per-lane words; expectations come from frame timing
//               arithmetic and bit-field extraction of those words.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_adc_frame_sequencer;

    localparam int F   = 16;
    localparam int LZ  = 4;
    localparam int DB  = 12;
    localparam int DIV = 2;
    localparam int Q   = 2;
    localparam int NCH = 2;
    localparam int DIV_B = 1;
    localparam int Q_B   = 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic enable_b = 1'b0;

    logic [NCH-1:0]    sdata = '0;
    logic              cs_n, sclk, busy, sample_valid;
    logic [NCH*DB-1:0] sample_data;
    logic [0:0]        sdata_b = '0;
    logic              cs_n_b, sclk_b, busy_b, sample_valid_b;
    logic [DB-1:0]     sample_data_b;
`ifdef ADC_SEQ_ZERO_CHECK_EN
    logic [NCH-1:0]    frame_err;
    logic [0:0]        frame_err_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_frame_sequencer #(
        .FRAME_BITS(F), .LEAD_ZEROS(LZ), .DATA_BITS(DB),
        .CLK_DIV(DIV), .QUIET_CYCLES(Q), .NUM_CH(NCH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sdata(sdata),
        .cs_n(cs_n), .sclk(sclk), .busy(busy),
        .sample_valid(sample_valid), .sample_data(sample_data)
`ifdef ADC_SEQ_ZERO_CHECK_EN
        , .frame_err(frame_err)
`endif
    );

    adc_frame_sequencer #(
        .FRAME_BITS(F), .LEAD_ZEROS(LZ), .DATA_BITS(DB),
        .CLK_DIV(DIV_B), .QUIET_CYCLES(Q_B), .NUM_CH(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .sdata(sdata_b),
        .cs_n(cs_n_b), .sclk(sclk_b), .busy(busy_b),
        .sample_valid(sample_valid_b), .sample_data(sample_data_b)
`ifdef ADC_SEQ_ZERO_CHECK_EN
        , .frame_err(frame_err_b)
`endif
    );

    // ---------------- behavioural ADCs ----------------
    // Each ADC latches its next word when cs_n falls, presents the MSB, and
    // moves to the next bit after every sclk falling edge.
    logic [F-1:0] next_a [NCH];
    logic [F-1:0] frame_a [NCH];
    logic [F-1:0] next_b, frame_b;
    int   idx_a = 0, idx_b = 0;
    logic prev_sclk_a = 1'b1, prev_cs_a = 1'b1;
    logic prev_sclk_b = 1'b1, prev_cs_b = 1'b1;

    always @(negedge clk) begin
        if (cs_n !== 1'b0) idx_a = 0;
        else if (prev_cs_a === 1'b1) begin
            for (int c = 0; c < NCH; c++) frame_a[c] = next_a[c];
            idx_a = 0;
        end else if (prev_sclk_a === 1'b1 && sclk === 1'b0) idx_a++;
        prev_sclk_a = sclk;
        prev_cs_a   = cs_n;
        for (int c = 0; c < NCH; c++) sdata[c] = (idx_a < F) ? frame_a[c][F-1-idx_a] : 1'b0;
    end

    always @(negedge clk) begin
        if (cs_n_b !== 1'b0) idx_b = 0;
        else if (prev_cs_b === 1'b1) begin
            frame_b = next_b;
            idx_b   = 0;
        end else if (prev_sclk_b === 1'b1 && sclk_b === 1'b0) idx_b++;
        prev_sclk_b = sclk_b;
        prev_cs_b   = cs_n_b;
        sdata_b[0]  = (idx_b < F) ? frame_b[F-1-idx_b] : 1'b0;
    end

    // ---------------- reference model ----------------
    function automatic logic [F-1:0] rand_stream();
        logic [F-1:0] s;
        s = 16'($urandom);
        if ($urandom_range(0, 1) == 0) s[F-1 -: LZ] = '0;
        return s;
    endfunction

    function automatic logic [DB-1:0] payload(input logic [F-1:0] s);
        return DB'(s >> (F - LZ - DB));
    endfunction

    function automatic logic lead_err(input logic [F-1:0] s);
        return (s >> (F - LZ)) != 0;
    endfunction

    function automatic logic [NCH*DB-1:0] exp_data_a();
        logic [NCH*DB-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) r[c*DB +: DB] = payload(frame_a[c]);
        return r;
    endfunction

    function automatic logic [NCH-1:0] exp_err_a();
        logic [NCH-1:0] e;
        for (int c = 0; c < NCH; c++) e[c] = lead_err(frame_a[c]);
        return e;
    endfunction

    // ---------------- bounded-wait helpers (no checking) ----------------
    task automatic wait_cs_fall_a(input int budget, output int n, output bit ok);
        n = 0; ok = 1'b0;
        while (!ok && n < budget) begin
            if (cs_n === 1'b0) ok = 1'b1;
            else begin @(negedge clk); n++; end
        end
    endtask

    // Called at the first negedge with cs_n low; returns at the first high one.
    task automatic measure_frame_a(input int drop_at, output int low, output int falls,
                                   output int strobes, output int not_busy);
        logic prev;
        low = 0; falls = 0; strobes = 0; not_busy = 0; prev = sclk;
        while (cs_n === 1'b0 && low < 1000) begin
            low++;
            if (sample_valid !== 1'b0) strobes++;
            if (busy !== 1'b1) not_busy++;
            @(negedge clk);
            if (prev === 1'b1 && sclk === 1'b0) begin
                falls++;
                if (falls == drop_at) enable = 1'b0;
            end
            prev = sclk;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int c = 0; c < NCH; c++) begin next_a[c] = '0; frame_a[c] = '0; end
        next_b = '0; frame_b = '0;
        reset_n = 1'b0; enable = 1'b0; enable_b = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, sclk, busy, sample_valid} !== 4'b1100 || sample_data !== '0) begin
            errors++;
            $display("FAIL reset_a: got cs_n/sclk/busy/valid=%b data=%h want 1100 data=0",
                     {cs_n, sclk, busy, sample_valid}, sample_data);
        end
        checks++;
        if ({cs_n_b, sclk_b, busy_b, sample_valid_b} !== 4'b1100 || sample_data_b !== '0) begin
            errors++;
            $display("FAIL reset_b: got %b data=%h want 1100 data=0",
                     {cs_n_b, sclk_b, busy_b, sample_valid_b}, sample_data_b);
        end
`ifdef ADC_SEQ_ZERO_CHECK_EN
        checks++;
        if (frame_err !== '0 || frame_err_b !== '0) begin
            errors++;
            $display("FAIL reset_frame_err: got %b/%b want 0/0", frame_err, frame_err_b);
        end
`endif
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cs_n !== 1'b1 || busy !== 1'b0 || sclk !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: got cs_n=%b busy=%b sclk=%b want 1 0 1", cs_n, busy, sclk);
        end
    endtask

    task automatic test_continuous();
        int n, low, falls, strobes, nb;
        bit ok;
        logic [NCH*DB-1:0] exp_d;
        next_a[0] = 16'h0ABC;
        next_a[1] = 16'h0123;
        enable = 1'b1;
        wait_cs_fall_a(10, n, ok);
        checks++;
        if (!ok || n != 1) begin
            errors++;
            $display("FAIL start_latency: got %0d cycles (ok=%0d) want 1", n, ok);
        end
        for (int f = 0; f < 5; f++) begin
            measure_frame_a(0, low, falls, strobes, nb);
            exp_d = exp_data_a();
            checks++;
            if (low != 2 * DIV * F || falls != F || strobes != 0 || nb != 0) begin
                errors++;
                $display("FAIL cont_frame%0d: got low=%0d falls=%0d strobes=%0d notbusy=%0d want %0d %0d 0 0",
                         f, low, falls, strobes, nb, 2 * DIV * F, F);
            end
            checks++;
            if (sample_valid !== 1'b1 || sample_data !== exp_d || sclk !== 1'b1) begin
                errors++;
                $display("FAIL cont_sample%0d: got valid=%b data=%h sclk=%b want 1 %h 1",
                         f, sample_valid, sample_data, sclk, exp_d);
            end
            if (f == 0) begin
                checks++;
                if (sample_data !== {12'h123, 12'hABC}) begin
                    errors++;
                    $display("FAIL cont_first_word: got %h want 123abc", sample_data);
                end
            end
`ifdef ADC_SEQ_ZERO_CHECK_EN
            checks++;
            if (frame_err !== exp_err_a()) begin
                errors++;
                $display("FAIL cont_frame_err%0d: got %b want %b", f, frame_err, exp_err_a());
            end
`endif
            for (int c = 0; c < NCH; c++) next_a[c] = rand_stream();
            wait_cs_fall_a(10, n, ok);
            checks++;
            if (!ok || n != Q) begin
                errors++;
                $display("FAIL cont_quiet%0d: got %0d (ok=%0d) want %0d", f, n, ok, Q);
            end
            checks++;
            if (sample_valid !== 1'b0 || sample_data !== exp_d) begin
                errors++;
                $display("FAIL cont_hold%0d: got valid=%b data=%h want 0 %h",
                         f, sample_valid, sample_data, exp_d);
            end
        end
    endtask

    // Entered at the first cs_n-low negedge of a running frame.
    task automatic test_enable_drop();
        int low, falls, strobes, nb, extra;
        measure_frame_a(8, low, falls, strobes, nb);
        checks++;
        if (low != 2 * DIV * F || falls != F || strobes != 0 || enable !== 1'b0) begin
            errors++;
            $display("FAIL drop_frame: got low=%0d falls=%0d strobes=%0d want %0d %0d 0",
                     low, falls, strobes, 2 * DIV * F, F);
        end
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== exp_data_a()) begin
            errors++;
            $display("FAIL drop_sample: got valid=%b data=%h want 1 %h",
                     sample_valid, sample_data, exp_data_a());
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cs_n !== 1'b1) begin
            errors++;
            $display("FAIL drop_quiet_busy: got busy=%b cs_n=%b want 1 1", busy, cs_n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b1) begin
            errors++;
            $display("FAIL drop_idle: got busy=%b cs_n=%b sclk=%b want 0 1 1", busy, cs_n, sclk);
        end
        extra = 0;
        repeat (100) begin
            @(negedge clk);
            if (cs_n !== 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL drop_no_restart: got %0d low cycles want 0", extra);
        end
    endtask

    task automatic test_single_pulse();
        int cs_falls, strobes;
        logic prev;
        logic [NCH*DB-1:0] got;
        got = '0;
        for (int c = 0; c < NCH; c++) next_a[c] = rand_stream();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        cs_falls = 0; strobes = 0; prev = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (prev === 1'b1 && cs_n === 1'b0) cs_falls++;
            if (sample_valid === 1'b1) begin strobes++; got = sample_data; end
            prev = cs_n;
            @(negedge clk);
        end
        checks++;
        if (cs_falls != 1 || strobes != 1) begin
            errors++;
            $display("FAIL pulse_count: got frames=%0d strobes=%0d want 1 1", cs_falls, strobes);
        end
        checks++;
        if (got !== exp_data_a()) begin
            errors++;
            $display("FAIL pulse_data: got %h want %h", got, exp_data_a());
        end
        checks++;
        if (busy !== 1'b0 || sclk !== 1'b1 || cs_n !== 1'b1) begin
            errors++;
            $display("FAIL pulse_idle: got busy=%b sclk=%b cs_n=%b want 0 1 1", busy, sclk, cs_n);
        end
    endtask

    task automatic test_zero_check();
        int n;
        next_a[0] = 16'h8ABC;
        next_a[1] = 16'h0ABC;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (sample_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (sample_valid !== 1'b1 || sample_data !== {12'hABC, 12'hABC}) begin
            errors++;
            $display("FAIL zero_chk_data: got valid=%b data=%h want 1 abcabc", sample_valid, sample_data);
        end
`ifdef ADC_SEQ_ZERO_CHECK_EN
        checks++;
        if (frame_err !== 2'b01) begin
            errors++;
            $display("FAIL zero_chk_err: got %b want 01", frame_err);
        end
`endif
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        int n, cnt, falls, low, strobes, nb;
        bit ok;
        logic prev;
        for (int c = 0; c < NCH; c++) next_a[c] = rand_stream();
        enable = 1'b1;
        wait_cs_fall_a(10, n, ok);
        falls = 0; cnt = 0; prev = sclk;
        while (falls < 10 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
            if (prev === 1'b1 && sclk === 1'b0) falls++;
            prev = sclk;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || falls != 10 || cs_n !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0 ||
            sample_valid !== 1'b0 || sample_data !== '0) begin
            errors++;
            $display("FAIL rst_abort: got falls=%0d cs_n=%b sclk=%b busy=%b valid=%b data=%h want 10 1 1 0 0 0",
                     falls, cs_n, sclk, busy, sample_valid, sample_data);
        end
        strobes = 0;
        repeat (3) begin
            @(negedge clk);
            if (sample_valid !== 1'b0) strobes++;
        end
        for (int c = 0; c < NCH; c++) next_a[c] = rand_stream();
        reset_n = 1'b1;
        wait_cs_fall_a(10, n, ok);
        checks++;
        if (strobes != 0 || !ok || n != 1) begin
            errors++;
            $display("FAIL rst_restart: got strobes=%0d latency=%0d ok=%0d want 0 1 1", strobes, n, ok);
        end
        measure_frame_a(0, low, falls, strobes, nb);
        checks++;
        if (low != 2 * DIV * F || falls != F || sample_valid !== 1'b1 ||
            sample_data !== exp_data_a()) begin
            errors++;
            $display("FAIL rst_full_frame: got low=%0d falls=%0d valid=%b data=%h want %0d %0d 1 %h",
                     low, falls, sample_valid, sample_data, 2 * DIV * F, F, exp_data_a());
        end
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    endtask

    task automatic test_config_b();
        int n, low, falls;
        logic prev;
        next_b = 16'hFFFF;
        enable_b = 1'b1;
        n = 0;
        while (cs_n_b !== 1'b0 && n < 10) begin @(negedge clk); n++; end
        for (int f = 0; f < 3; f++) begin
            low = 0; falls = 0; prev = sclk_b;
            while (cs_n_b === 1'b0 && low < 1000) begin
                low++;
                @(negedge clk);
                if (prev === 1'b1 && sclk_b === 1'b0) falls++;
                prev = sclk_b;
            end
            checks++;
            if (low != 2 * DIV_B * F || falls != F) begin
                errors++;
                $display("FAIL b_frame%0d: got low=%0d falls=%0d want %0d %0d", f, low, falls, 2 * DIV_B * F, F);
            end
            checks++;
            if (sample_valid_b !== 1'b1 || sample_data_b !== payload(frame_b) ||
                (f == 0 && sample_data_b !== 12'hFFF)) begin
                errors++;
                $display("FAIL b_sample%0d: got valid=%b data=%h want 1 %h", f, sample_valid_b,
                         sample_data_b, payload(frame_b));
            end
`ifdef ADC_SEQ_ZERO_CHECK_EN
            checks++;
            if (frame_err_b !== lead_err(frame_b)) begin
                errors++;
                $display("FAIL b_frame_err%0d: got %b want %b", f, frame_err_b, lead_err(frame_b));
            end
`endif
            next_b = rand_stream();
            if (f == 2) enable_b = 1'b0;
            n = 0;
            while (cs_n_b !== 1'b0 && n < 10) begin @(negedge clk); n++; end
            checks++;
            if ((f < 2 && n != Q_B) || (f == 2 && (n != 10 || busy_b !== 1'b0 || sclk_b !== 1'b1))) begin
                errors++;
                $display("FAIL b_quiet%0d: got gap=%0d busy=%b want %0d", f, n, busy_b,
                         (f < 2) ? Q_B : 10);
            end
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_enable_drop();
        test_single_pulse();
        test_zero_check();
        test_reset_midframe();
        test_config_b();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adc_frame_sequencer.md
Name: adc_frame_sequencer

Overview:
Generates chip-select and serial clock for one or more SPI-style ADCs sharing a single sclk/cs_n. It counts sclk falling edges per conversion frame and deserialises each channel's sdata lane MSB-first. It emits a parallel sample word with a one-cycle valid strobe. It sits between the ADC pins and the sample FIFO/USB packetiser, and runs entirely in the system clock domain; sclk is a divided, registered output.

Parameters:
- FRAME_BITS, 16: sclk falling edges per frame.
- LEAD_ZEROS, 4: leading frame bits discarded before data.
- DATA_BITS, 12: payload bits per channel; LEAD_ZEROS+DATA_BITS <= FRAME_BITS (elaboration error otherwise). Trailing bits are ignored.
- CLK_DIV, 2: sclk half-period in clk cycles, >= 1.
- QUIET_CYCLES, 2: minimum clk cycles cs_n is high between frames, >= 1.
- NUM_CH, 2: parallel ADC lanes sharing sclk/cs_n.

Ports:
- clk, input, 1: system clock; all logic on posedge.
- reset_n, input, 1: reset, asynchronous, active-low.
- enable, input, 1: level; frames run back-to-back while high.
- sdata, input, NUM_CH: serial data lanes, one per ADC.
- cs_n, output, 1: ADC chip select, active low.
- sclk, output, 1: ADC serial clock, idles high.
- busy, output, 1: high while a frame or quiet period is in progress.
- sample_valid, output, 1: one-cycle strobe.
- sample_data, output, NUM_CH*DATA_BITS: channel c occupies bits [c*DATA_BITS +: DATA_BITS].

Behaviour:
- Reset values (asynchronous): cs_n=1, sclk=1, busy=0, sample_valid=0, sample_data=0, state=IDLE, all counters 0.
- States:
  - IDLE: cs_n=1, sclk=1. If enable=1, go to SHIFT on the next edge and drive cs_n=0 on that edge.
  - SHIFT:
    - A divider counts 0..CLK_DIV-1; on wrap, sclk toggles.
    - Each 1->0 toggle is a falling-edge event. In that same clk cycle, sample sdata for every lane into its shift register, then increment the edge counter.
    - Falling edge k (1-based) captures frame bit k-1, MSB first.
    - After falling edge FRAME_BITS and the following rising toggle, go to QUIET.
    - cs_n is low for exactly 2*CLK_DIV*FRAME_BITS clk cycles.
  - QUIET:
    - On entry, cs_n=1, sample_valid=1 for one cycle, and sample_data updates to frame bits [LEAD_ZEROS .. LEAD_ZEROS+DATA_BITS-1] per lane.
    - Hold for QUIET_CYCLES cycles, counted from entry.
    - Then go to SHIFT if enable=1, else IDLE.
- Frame period with continuous enable: 2*CLK_DIV*FRAME_BITS + QUIET_CYCLES clk cycles.
- busy = (state != IDLE).
- Edge counter width is $clog2(FRAME_BITS+1). It clears on entering SHIFT and never wraps mid-frame.
- enable falling mid-frame: the frame completes and emits its sample, then returns to IDLE. enable has no effect during QUIET until its final cycle.
- enable is sampled only in IDLE and on the last QUIET cycle.
- Reset mid-frame: immediate abort, cs_n=1, sclk=1, no sample_valid; the partial frame is discarded.
- sample_data holds its last value between strobes.

Optional Feature:
- Macro: ADC_SEQ_ZERO_CHECK_EN.
- When defined:
  - Adds output frame_err [NUM_CH-1:0], reset 0.
  - Updates together with sample_valid.
  - Bit c=1 if any of lane c's first LEAD_ZEROS captured bits was 1; it is still set on that frame's strobe.
- When undefined: no port, no check logic.

Decomposition:
- Package adc_pkg holds:
  - state enum {IDLE, SHIFT, QUIET};
  - localparam widths via $clog2 for the divider, edge and quiet counters;
  - the LEAD_ZEROS+DATA_BITS <= FRAME_BITS check helper.
- One natural sub-module: adc_sclk_div. It contains the divider and sclk register, has a run input, and outputs sclk, fall_evt and rise_evt. The sequencer FSM, per-lane shift registers and output register stay in the top.

Test Plan:
- Defaults, enable held high, lanes driving 16'h0ABC and 16'h0123 -> cs_n low 64 cycles, 16 sclk falls; sample_valid on the cs_n rising edge with sample_data = {12'h123, 12'hABC}; next cs_n fall 2 cycles later; period 66.
- Single frame: enable pulsed for 1 cycle in IDLE -> exactly one frame, one strobe, then IDLE with busy=0 and sclk=1.
- enable deasserted at falling edge 8 -> frame completes, strobe fires, return to IDLE after QUIET; no further cs_n fall.
- reset_n asserted at falling edge 10 -> same-cycle cs_n=1, sclk=1, sample_valid never asserts; after release with enable=1, a full 64-cycle frame follows.
- CLK_DIV=1, FRAME_BITS=16, QUIET_CYCLES=1, NUM_CH=1, sdata=16'hFFFF -> cs_n low 32 cycles, sample_data=12'hFFF; frame_err=1 when ADC_SEQ_ZERO_CHECK_EN is defined.
- Lane 0 stream 16'h8ABC, lane 1 16'h0ABC with ADC_SEQ_ZERO_CHECK_EN -> frame_err=2'b01, sample_data={12'hABC,12'hABC}.
